// File: rtl/bandit_environment.sv
// Synthetic multi-armed-bandit environment: per-arm Bernoulli success probability
// and reward magnitude, with a 16-bit Galois LFSR as the randomness source.
module bandit_environment #(
  parameter int          ACTIONS = 256,
  parameter int          WIDTH   = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             action_valid,
  input  logic [WIDTH-1:0] action_data,
  output logic             action_ready,
  output logic             reward_valid,
  output logic [WIDTH-1:0] reward_data,
  input  logic             reward_ready,
  input  logic             config_valid,
  input  logic [WIDTH-1:0] config_addr,
  input  logic [WIDTH-1:0] config_prob,
  input  logic [WIDTH-1:0] config_value,
  output logic             config_ready,
  output logic [15:0]      pull_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid and data are held stable by the source until that edge.

  localparam int AW = (ACTIONS > 1) ? $clog2(ACTIONS) : 1;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    LOOKUP  = 2'd2,
    RESPOND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] arm_q, arm_d;
  logic [WIDTH-1:0] reward_q, reward_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      pulls_q, pulls_d;

  logic [WIDTH-1:0] prob_mem  [ACTIONS];
  logic [WIDTH-1:0] value_mem [ACTIONS];

  logic             act_hs, cfg_hs;
  logic             arm_in_range, cfg_in_range, success;
  logic [WIDTH-1:0] rd_prob, rd_value, rnd;

  assign action_ready = (state_q == IDLE);
  assign config_ready = (state_q == IDLE);
  assign reward_valid = (state_q == RESPOND);
  assign reward_data  = reward_q;
  assign pull_count   = pulls_q;
  assign state_dbg    = state_q;

  assign act_hs       = action_valid && action_ready;
  assign cfg_hs       = config_valid && config_ready;
  assign arm_in_range = (32'(arm_q) < ACTIONS);
  assign cfg_in_range = (32'(config_addr) < ACTIONS);

  // The table is read with the arm latched at accept, so a config write landing
  // on the accept edge is already visible here.
  assign rd_prob  = prob_mem[arm_q[AW-1:0]];
  assign rd_value = value_mem[arm_q[AW-1:0]];
  assign rnd      = lfsr_q[WIDTH-1:0];
  assign success  = (rd_prob == '1) || (rnd < rd_prob);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    arm_d    = arm_q;
    reward_d = reward_q;
    lfsr_d   = lfsr_q;
    pulls_d  = pulls_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(ACTIONS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (act_hs) begin
          arm_d   = action_data;
          pulls_d = (pulls_q == 16'hFFFF) ? pulls_q : pulls_q + 16'd1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        reward_d = (arm_in_range && success) ? rd_value : '0;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        state_d  = RESPOND;
      end
      RESPOND: begin
        if (reward_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      arm_q    <= '0;
      reward_q <= '0;
      lfsr_q   <= SEED;
      pulls_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      arm_q    <= arm_d;
      reward_q <= reward_d;
      lfsr_q   <= lfsr_d;
      pulls_q  <= pulls_d;
    end
  end

  // Tables carry no reset; INIT sweeps them to zero after every reset.
  always_ff @(posedge clock) begin
    if (state_q == INIT) begin
      prob_mem[ptr_q]  <= '0;
      value_mem[ptr_q] <= '0;
    end else if (cfg_hs && cfg_in_range) begin
      prob_mem[config_addr[AW-1:0]]  <= config_prob;
      value_mem[config_addr[AW-1:0]] <= config_value;
    end
  end

endmodule

// File: tb/tb_bandit_environment.sv
// Directed bench for bandit_environment: init timing, table programming,
// reference-LFSR reward scoreboard, back-pressure and reset-while-pending.
module tb_bandit_environment;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         action_valid = 1'b0;
  logic [W-1:0] action_data = '0;
  logic         action_ready;
  logic         reward_valid;
  logic [W-1:0] reward_data;
  logic         reward_ready = 1'b0;
  logic         config_valid = 1'b0;
  logic [W-1:0] config_addr = '0;
  logic [W-1:0] config_prob = '0;
  logic [W-1:0] config_value = '0;
  logic         config_ready;
  logic [15:0]  pull_count;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   m_prob [256];
  logic [7:0]   m_val  [256];
  logic [15:0]  m_lfsr;
  int           m_pulls;

  bandit_environment #(.ACTIONS(256), .WIDTH(8), .SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset),
    .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
    .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
    .config_valid(config_valid), .config_addr(config_addr), .config_prob(config_prob),
    .config_value(config_value), .config_ready(config_ready),
    .pull_count(pull_count), .state_dbg(state_dbg)
  );

  // clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference environment: Bernoulli draw from the LFSR low byte, then one
  // Galois right-shift step with taps 16'hB400.
  task automatic model_pull(input logic [7:0] arm, output logic [7:0] r);
    logic [7:0] rnd;
    rnd = m_lfsr[7:0];
    r = (m_prob[arm] == 8'hFF || rnd < m_prob[arm]) ? m_val[arm] : 8'h00;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_pulls++;
  endtask

  // Assert reset, check reset values, release and time the INIT sweep.
  task automatic do_reset();
    int early;
    @(negedge clock);
    reset = 1'b1; action_valid = 1'b0; config_valid = 1'b0; reward_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_action_ready", action_ready, 0);
    check("rst_reward_valid", reward_valid, 0);
    check("rst_reward_data", reward_data, 0);
    check("rst_config_ready", config_ready, 0);
    check("rst_pull_count", pull_count, 0);
    for (int i = 0; i < 256; i++) begin
      m_prob[i] = 8'h00;
      m_val[i]  = 8'h00;
    end
    m_lfsr = 16'hACE1;
    m_pulls = 0;
    exp_q.delete();
    reset = 1'b0;
    early = 0;
    for (int i = 1; i < 256; i++) begin
      @(posedge clock); @(negedge clock);
      if (action_ready || reward_valid || config_ready) early++;
    end
    check("init_early_ready", early, 0);
    @(posedge clock); @(negedge clock);
    check("init_exit_256", action_ready, 1);
    check("init_config_ready", config_ready, 1);
    check("init_pull_count", pull_count, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!action_ready && n < 400) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    if (!action_ready) check("idle_timeout", action_ready, 1);
  endtask

  task automatic cfg(input logic [7:0] addr, input logic [7:0] prob, input logic [7:0] val);
    wait_idle();
    config_valid = 1'b1; config_addr = addr; config_prob = prob; config_value = val;
    m_prob[addr] = prob;
    m_val[addr]  = val;
    @(posedge clock); @(negedge clock);
    config_valid = 1'b0;
  endtask

  // One action/reward round trip; optional same-edge config and back-pressure hold.
  task automatic pull(input logic [7:0] arm, input int hold, input bit with_cfg,
                      input logic [7:0] cp, input logic [7:0] cv, output logic [7:0] got);
    logic [7:0] e;
    logic [7:0] first;
    int         errs;
    wait_idle();
    if (with_cfg) begin
      check("same_cfg_ready", config_ready, 1);
      config_valid = 1'b1; config_addr = arm; config_prob = cp; config_value = cv;
      m_prob[arm] = cp;
      m_val[arm]  = cv;
    end
    action_valid = 1'b1;
    action_data  = arm;
    model_pull(arm, e);
    exp_q.push_back(e);
    @(posedge clock); @(negedge clock);
    action_valid = 1'b0;
    config_valid = 1'b0;
    check("lookup_valid_low", reward_valid, 0);
    @(posedge clock); @(negedge clock);
    check("respond_valid", reward_valid, 1);
    if (hold > 0) begin
      first = reward_data;
      errs  = 0;
      config_valid = 1'b1; config_addr = arm; config_prob = 8'h00; config_value = 8'h55;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); @(negedge clock);
        if (!reward_valid || reward_data !== first || action_ready || config_ready) errs++;
      end
      config_valid = 1'b0;
      check("hold_stable", errs, 0);
    end
    got = reward_data;
    if (exp_q.size() != 0) check("reward_data", reward_data, exp_q.pop_front());
    else check("sb_underflow", exp_q.size(), 1);
    reward_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    reward_ready = 1'b0;
    check("post_hs_valid", reward_valid, 0);
    check("post_hs_action_ready", action_ready, 1);
  endtask

  initial begin
    logic [7:0] got;
    int         succ;
    int         odd;

    // init timing and reset values
    do_reset();

    // empty table: every arm yields zero
    pull(8'd0, 0, 1'b0, 8'h00, 8'h00, got);
    check("zero_arm0", got, 8'h00);
    pull(8'd64, 0, 1'b0, 8'h00, 8'h00, got);
    check("zero_arm64", got, 8'h00);
    pull(8'd255, 0, 1'b0, 8'h00, 8'h00, got);
    check("zero_arm255", got, 8'h00);
    check("pulls_3", pull_count, 3);

    // certain success on arm 64
    do_reset();
    cfg(8'd64, 8'hFF, 8'd3);
    odd = 0;
    for (int i = 0; i < 100; i++) begin
      pull(8'd64, 0, 1'b0, 8'h00, 8'h00, got);
      if (got !== 8'd3) odd++;
    end
    check("always_3", odd, 0);
    check("pulls_100", pull_count, 100);

    // half-probability arm against the reference LFSR
    cfg(8'd7, 8'h80, 8'hFE);
    succ = 0;
    odd  = 0;
    for (int i = 0; i < 1000; i++) begin
      pull(8'd7, 0, 1'b0, 8'h00, 8'h00, got);
      if (got == 8'hFE) succ++;
      else if (got != 8'h00) odd++;
    end
    check("half_values", odd, 0);
    check("half_success_range", (succ >= 450 && succ <= 550), 1);
    check("pulls_1100", pull_count, 32'(m_pulls));

    // back-pressure: reward held, config offered meanwhile must be ignored
    pull(8'd64, 10, 1'b0, 8'h00, 8'h00, got);
    check("hold_reward", got, 8'd3);
    pull(8'd64, 0, 1'b0, 8'h00, 8'h00, got);
    check("cfg_ignored_in_respond", got, 8'd3);

    // config and action on the same edge, same arm
    pull(8'd5, 0, 1'b1, 8'hFF, 8'd9, got);
    check("same_edge_reward", got, 8'd9);

    // reset while a reward is pending
    wait_idle();
    action_valid = 1'b1; action_data = 8'd5;
    @(posedge clock); @(negedge clock);
    action_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    check("pending_valid", reward_valid, 1);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("mid_rst_valid", reward_valid, 0);
    check("mid_rst_state", state_dbg, 2'd0);
    check("mid_rst_pulls", pull_count, 0);
    do_reset();
    pull(8'd5, 0, 1'b0, 8'h00, 8'h00, got);
    check("table_cleared", got, 8'h00);
    check("pulls_after_rst", pull_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
